pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch sequencer that owns the program counter and drives the instruction-memory port. It issues one fetch at a time from the current PC and presents each fetched instruction with its PC to decode. It holds the instruction while the pipeline stalls, then advances the PC by 4. A branch or jump redirect reloads the PC and squashes any fetch already in flight. It replaces the free-running enable-gated PC register plus adder at the front of the core.

## Interface
Parameters:
- ResetVector, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  decode cannot accept; held instruction stays valid.
- RedirectValid  in  1  load RedirectTarget into PC this cycle.
- RedirectTarget  in  32  branch/jump target address.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  32  fetch address; equals PC while IMemReq=1.
- IMemGnt  in  1  memory accepts request this cycle.
- IMemRespValid  in  1  read data valid, one cycle, for the oldest accepted request.
- IMemRdata  in  32  read data.
- InstrValid  out  1  Instr/InstrPC valid for decode.
- Instr  out  32  fetched instruction.
- InstrPC  out  32  address of Instr.
- PC  out  32  current program counter.
- AlignFault  out  1  misaligned redirect pulse; see Configuration.

## Operation
- States: ISSUE, WAIT, HOLD. Squash flag (1 bit) accompanies WAIT.
- ISSUE:
  - IMemReq=1, IMemAddr=PC.
  - IMemGnt -> WAIT.
  - Redirect without grant: PC<=target, stay ISSUE.
  - Redirect with grant: PC<=target, WAIT with Squash=1.
- WAIT:
  - IMemReq=0.
  - IMemRespValid with Squash=0 and no redirect: Instr<=IMemRdata, InstrPC<=PC, PC<=PC+4, -> HOLD.
  - IMemRespValid with Squash=1: discard data, clear Squash, -> ISSUE.
  - Redirect with no response: PC<=target, Squash<=1, stay WAIT.
  - Redirect with response the same cycle: discard data, PC<=target, -> ISSUE.
- HOLD:
  - InstrValid=1.
  - Stall=1: hold Instr/InstrPC unchanged.
  - Stall=0: instruction consumed this cycle, -> ISSUE.
  - Redirect, regardless of Stall: PC<=target, InstrValid drops next cycle, -> ISSUE.
- Redirect has priority over every other event in every state.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Only one outstanding request. IMemReq is never asserted in WAIT or HOLD.

## Timing
- Reset values: state=ISSUE, PC=ResetVector, Squash=0, InstrValid=0, Instr=0, InstrPC=0, AlignFault=0.
- IMemReq=1 in the first cycle after Reset deasserts.
- Reset asserted mid-fetch abandons the transaction. Any later IMemRespValid arriving in ISSUE is ignored.
- All outputs come from registers or decode of the state register only. No input-to-output combinational path.
- Minimum throughput: grant in cycle 0, response in cycle 1, InstrValid=1 in cycle 2, next IMemReq in cycle 3. That is 3 cycles per instruction.
- Redirect in cycle N: PC=target in cycle N+1. IMemReq with IMemAddr=target no later than the cycle after any squashed response returns.

## Configuration
- PC_FETCH_CTRL_ALIGN_CHECK_EN defined:
  - A redirect with RedirectTarget[1:0]!=0 is rejected. PC, state and Squash are unchanged, as if RedirectValid=0.
  - AlignFault=1 for exactly the following cycle.
- Not defined:
  - RedirectTarget[1:0] is forced to 2'b00 silently.
  - AlignFault is tied to 0; the port always exists.

## Structure
- Shared package pc_fetch_pkg holds:
  - state enum (ISSUE, WAIT, HOLD)
  - INSTR_BYTES=4
  - default reset vector constant
- PC+4 uses the existing ADD module, instantiated once. All other logic is inline.

## Test plan
- Reset, then memory grants immediately and responds next cycle with data 32'h2000_0001 etc., Stall=0 -> InstrPC sequence 0,4,8,… with InstrValid every 3rd cycle.
- Stall=1 for 4 cycles while in HOLD -> Instr/InstrPC stable, no IMemReq. After Stall=0, next IMemAddr=InstrPC+4.
- Redirect to 32'h0000_0100 in WAIT, response 2 cycles later -> response discarded, no InstrValid, next IMemAddr=32'h100.
- Redirect with grant in the same ISSUE cycle, and separately with response in the same WAIT cycle -> no stale InstrValid, next fetch at target.
- ResetVector=32'hFFFF_FFFC -> first InstrPC=32'hFFFF_FFFC, second IMemAddr=32'h0.
- With macro, redirect to 32'h0000_0102 -> AlignFault pulses 1 cycle, PC unchanged. Without macro -> next IMemAddr=32'h100, AlignFault=0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pc_fetch_pkg;

  // Fetch sequencer states. The squash flag travels alongside WAIT.
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Every instruction is one 32-bit word.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // PC value loaded on reset unless the instance overrides it.
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Clears the byte-offset bits of an address to force word alignment.
  localparam logic [31:0] ALIGN_MASK = ~(INSTR_BYTES - 32'd1);

endpackage

// File: rtl/pc_fetch_ctrl_add.sv
// Plain modulo adder used for the PC increment.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module pc_fetch_ctrl_add #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] sum
);

  // Carry out is intentionally dropped so the result wraps modulo 2^Width.
  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Owns the PC, issues one instruction fetch at a time and holds the result for decode.
// Latency: grant -> response -> InstrValid the following cycle; 3 cycles per instruction minimum.
// Backpressure: Stall holds the instruction in HOLD; no new request is issued until it is consumed.
// Optional feature: define PC_FETCH_CTRL_ALIGN_CHECK_EN to reject misaligned redirects and pulse AlignFault.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] ResetVector = DEFAULT_RESET_VECTOR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRespValid,
  input  logic [31:0] IMemRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PC,
  output logic        AlignFault
);

  fetch_state_e state_q, state_d;
  logic         squash_q, squash_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         capture;
  logic [31:0]  pc_plus4;

  // Accepted redirect and its effective target after alignment handling.
  logic         redir;
  logic [31:0]  redir_tgt;

`ifdef PC_FETCH_CTRL_ALIGN_CHECK_EN
  logic misaligned;
  logic align_fault_q;

  assign misaligned = (RedirectTarget[1:0] != 2'b00);
  // A misaligned redirect is dropped entirely, as if it never arrived.
  assign redir      = RedirectValid && !misaligned;
  assign redir_tgt  = RedirectTarget;

  // Single-cycle fault pulse in the cycle after a rejected redirect.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= RedirectValid && misaligned;
    end
  end

  assign AlignFault = align_fault_q;
`else
  // Low address bits are silently cleared so the PC stays word aligned.
  assign redir      = RedirectValid;
  assign redir_tgt  = RedirectTarget & ALIGN_MASK;
  assign AlignFault = 1'b0;
`endif

  pc_fetch_ctrl_add #(
    .Width (32)
  ) u_pc_add (
    .a   (pc_q),
    .b   (INSTR_BYTES),
    .sum (pc_plus4)
  );

  // Next-state logic; a redirect outranks grant, response and stall in every state.
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    pc_d     = pc_q;
    capture  = 1'b0;
    case (state_q)
      ISSUE: begin
        if (redir) begin
          pc_d = redir_tgt;
          if (IMemGnt) begin
            // The granted request is for the old PC; its data must be dropped.
            state_d  = WAIT;
            squash_d = 1'b1;
          end
        end else if (IMemGnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redir) begin
          pc_d = redir_tgt;
          if (IMemRespValid) begin
            // Response for the stale request lands now; nothing left in flight.
            state_d  = ISSUE;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (IMemRespValid) begin
          if (squash_q) begin
            state_d  = ISSUE;
            squash_d = 1'b0;
          end else begin
            capture = 1'b1;
            pc_d    = pc_plus4;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = redir_tgt;
          state_d = ISSUE;
        end else if (!Stall) begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d  = ISSUE;
        squash_d = 1'b0;
      end
    endcase
  end

  // State, PC and held-instruction registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ISSUE;
      squash_q   <= 1'b0;
      pc_q       <= ResetVector;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      pc_q     <= pc_d;
      if (capture) begin
        instr_q    <= IMemRdata;
        instr_pc_q <= pc_q;
      end
    end
  end

  // All outputs come from registers or a decode of the state register.
  assign IMemReq    = (state_q == ISSUE);
  assign IMemAddr   = pc_q;
  assign InstrValid = (state_q == HOLD);
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign PC         = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for the fetch sequencer with directed stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_fetch_ctrl;

  logic        Clock = 1'b0;
  logic        Reset, Stall, RedirectValid, IMemGnt, IMemRespValid;
  logic [31:0] RedirectTarget, IMemRdata;

  logic        IMemReq, InstrValid, AlignFault;
  logic [31:0] IMemAddr, Instr, InstrPC, PC;

  logic        w_IMemReq, w_InstrValid, w_AlignFault;
  logic [31:0] w_IMemAddr, w_Instr, w_InstrPC, w_PC;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];
  logic [31:0] mon_a;
  logic [63:0] mon_e;
  logic [31:0] nxt;

  always #5 Clock = ~Clock;

  pc_fetch_ctrl u_dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall),
    .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRespValid(IMemRespValid), .IMemRdata(IMemRdata),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC),
    .PC(PC), .AlignFault(AlignFault)
  );

  pc_fetch_ctrl #(.ResetVector(32'hFFFF_FFFC)) u_wrap (
    .Clock(Clock), .Reset(Reset), .Stall(Stall),
    .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
    .IMemReq(w_IMemReq), .IMemAddr(w_IMemAddr), .IMemGnt(IMemGnt),
    .IMemRespValid(IMemRespValid), .IMemRdata(IMemRdata),
    .InstrValid(w_InstrValid), .Instr(w_Instr), .InstrPC(w_InstrPC),
    .PC(w_PC), .AlignFault(w_AlignFault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compares accepted requests and consumed instructions against the queues.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (IMemGnt) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant addr=%h required=none", IMemAddr);
        end else begin
          mon_a = exp_addr_q.pop_front();
          chk("req_vld", {31'h0, IMemReq}, 32'h1);
          chk("req_addr", IMemAddr, mon_a);
        end
      end
      if (InstrValid && !Stall) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stale_instr instr_pc=%h required=none", InstrPC);
        end else begin
          mon_e = exp_instr_q.pop_front();
          chk("instr", Instr, mon_e[63:32]);
          chk("instr_pc", InstrPC, mon_e[31:0]);
        end
      end
      chk("req_while_valid", {31'h0, IMemReq && InstrValid}, 32'h0);
    end
  end

  task automatic cyc(input logic gnt, input logic rsp, input logic [31:0] rd,
                     input logic stl, input logic rv, input logic [31:0] rt);
    IMemGnt        = gnt;
    IMemRespValid  = rsp;
    IMemRdata      = rd;
    Stall          = stl;
    RedirectValid  = rv;
    RedirectTarget = rt;
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_instr_q.push_back({data, addr});
    cyc(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    Stall = 1'b0; RedirectValid = 1'b0; RedirectTarget = 32'h0;
    IMemGnt = 1'b0; IMemRespValid = 1'b0; IMemRdata = 32'h0;
    repeat (3) @(posedge Clock);
    #1;
    // Reset state
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr_vld", {31'h0, InstrValid}, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_instr_pc", InstrPC, 32'h0);
    chk("rst_align_fault", {31'h0, AlignFault}, 32'h0);
    chk("rst_wrap_pc", w_PC, 32'hFFFF_FFFC);
    Reset = 1'b0;
    chk("first_req", {31'h0, IMemReq}, 32'h1);
    chk("first_addr", IMemAddr, 32'h0);
    chk("wrap_first_addr", w_IMemAddr, 32'hFFFF_FFFC);

    // Back-to-back fetches; the wrap instance sees the same memory traffic.
    exp_addr_q.push_back(32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_instr_q.push_back({32'h2000_0001, 32'h0});
    cyc(1'b0, 1'b1, 32'h2000_0001, 1'b0, 1'b0, 32'h0);
    chk("wrap_instr_pc", w_InstrPC, 32'hFFFF_FFFC);
    chk("wrap_instr_vld", {31'h0, w_InstrValid}, 32'h1);
    chk("wrap_pc", w_PC, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_second_req", {31'h0, w_IMemReq}, 32'h1);
    chk("wrap_second_addr", w_IMemAddr, 32'h0);
    fetch(32'h4, 32'h2000_0002);
    fetch(32'h8, 32'h2000_0003);
    fetch(32'hC, 32'h2000_0004);

    // Stall in HOLD for 4 cycles
    exp_addr_q.push_back(32'h10);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    exp_instr_q.push_back({32'hA5A5_0010, 32'h10});
    cyc(1'b0, 1'b1, 32'hA5A5_0010, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("stall_vld", {31'h0, InstrValid}, 32'h1);
      chk("stall_instr", Instr, 32'hA5A5_0010);
      chk("stall_instr_pc", InstrPC, 32'h10);
      chk("stall_no_req", {31'h0, IMemReq}, 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    fetch(32'h14, 32'h2000_0014);

    // Redirect in WAIT, stale response two cycles later
    exp_addr_q.push_back(32'h18);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    chk("redir_wait_pc", PC, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk("squash_no_vld", {31'h0, InstrValid}, 32'h0);
    chk("squash_refetch_addr", IMemAddr, 32'h100);
    fetch(32'h100, 32'h3000_0100);

    // Redirect together with grant in ISSUE
    exp_addr_q.push_back(32'h104);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    chk("redir_gnt_pc", PC, 32'h200);
    cyc(1'b0, 1'b1, 32'hBAD0_0104, 1'b0, 1'b0, 32'h0);
    chk("redir_gnt_no_vld", {31'h0, InstrValid}, 32'h0);
    fetch(32'h200, 32'h3000_0200);

    // Redirect together with response in WAIT
    exp_addr_q.push_back(32'h204);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'hBAD0_0204, 1'b0, 1'b1, 32'h300);
    chk("redir_rsp_pc", PC, 32'h300);
    chk("redir_rsp_no_vld", {31'h0, InstrValid}, 32'h0);
    fetch(32'h300, 32'h3000_0300);

    // Misaligned redirect in ISSUE
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
`ifdef PC_FETCH_CTRL_ALIGN_CHECK_EN
    nxt = 32'h304;
    chk("misalign_pc", PC, nxt);
    chk("misalign_fault", {31'h0, AlignFault}, 32'h1);
`else
    nxt = 32'h100;
    chk("misalign_pc", PC, nxt);
    chk("misalign_fault", {31'h0, AlignFault}, 32'h0);
`endif
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("misalign_fault_end", {31'h0, AlignFault}, 32'h0);
    fetch(nxt, 32'h4000_0001);
    nxt = nxt + 32'd4;

    // Reset mid-fetch; the late response in ISSUE must be ignored
    exp_addr_q.push_back(nxt);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b0;
    cyc(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
    chk("late_rsp_no_vld", {31'h0, InstrValid}, 32'h0);
    chk("late_rsp_req", {31'h0, IMemReq}, 32'h1);
    chk("late_rsp_pc", PC, 32'h0);
    fetch(32'h0, 32'h5000_0000);

    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("addr_queue_drained", exp_addr_q.size(), 32'h0);
    chk("instr_queue_drained", exp_instr_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
